// File: rtl/adc_input_aligner.sv
// Receive-side ADC word aligner: measures calibration-pulse round-trip latency and
// delays the 16-sample ADC stream so the total loop latency is constant.
module adc_input_aligner #(
  parameter int NUM_STAGES = 16,
  parameter int SAMPLE_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [16*SAMPLE_W-1:0]   adc_word_in,
  input  logic                     adc_valid_in,
  input  logic                     cal_start,
  input  logic [SAMPLE_W-1:0]      threshold,
  input  logic                     delay_override_en,
  input  logic [7:0]               delay_override,
  output logic [16*SAMPLE_W-1:0]   adc_word_out,
  output logic                     adc_valid_out,
  output logic                     cal_busy,
  output logic                     cal_done,
  output logic                     cal_timeout,
  output logic [7:0]               measured_delay,
  output logic [7:0]               applied_delay
);

  localparam int WORD_W        = 16 * SAMPLE_W;
  localparam int WIN_N         = (NUM_STAGES + 1) * 16;
  localparam int IDX_W         = $clog2(WIN_N);
  localparam int WC_W          = $clog2(NUM_STAGES);
  localparam int MAX_DELAY_INT = NUM_STAGES * 16 - 1;
  localparam logic [7:0]      MAX_DELAY = 8'(MAX_DELAY_INT);
  localparam logic [WC_W-1:0] WC_LAST   = WC_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [WORD_W-1:0]   hist [NUM_STAGES];
  logic [SAMPLE_W-1:0] win  [WIN_N];
  logic [WORD_W-1:0]   aligned;
  logic [WC_W-1:0]     wc;
  logic [15:0]         over;
  logic                hit;
  logic [3:0]          hit_k;
  logic [7:0]          measured_next;
  logic [7:0]          calib_delay;

  function automatic logic [7:0] clamp_delay(input logic [7:0] d);
    if (int'(d) > MAX_DELAY_INT) begin
      clamp_delay = MAX_DELAY;
    end else begin
      clamp_delay = d;
    end
  endfunction

  // Sample window, oldest history sample at index 0, current word on top.
  always_comb begin
    for (int h = 0; h < NUM_STAGES; h++) begin
      for (int s = 0; s < 16; s++) begin
        win[(NUM_STAGES-1-h)*16 + s] = hist[h][s*SAMPLE_W +: SAMPLE_W];
      end
    end
    for (int s = 0; s < 16; s++) begin
      win[NUM_STAGES*16 + s] = adc_word_in[s*SAMPLE_W +: SAMPLE_W];
    end
  end

  // Output sample k is taken applied_delay samples behind input sample k.
  always_comb begin
    logic [IDX_W-1:0] idx;
    aligned = '0;
    idx     = '0;
    for (int k = 0; k < 16; k++) begin
      idx = IDX_W'(NUM_STAGES*16 + k) - IDX_W'(applied_delay);
      aligned[k*SAMPLE_W +: SAMPLE_W] = win[idx];
    end
  end

  // Lowest-index sample strictly above threshold wins.
  always_comb begin
    over  = '0;
    hit_k = 4'd0;
    for (int k = 0; k < 16; k++) begin
      over[k] = $signed(adc_word_in[k*SAMPLE_W +: SAMPLE_W]) > $signed(threshold);
    end
    for (int k = 15; k >= 0; k--) begin
      hit_k = over[k] ? 4'(k) : hit_k;
    end
    hit           = |over;
    measured_next = 8'({wc, hit_k});
  end

  // Calibration FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, TIMEOUT: begin
        state_next = cal_start ? SEARCH : state;
      end
      SEARCH: begin
        if (adc_valid_in && hit) begin
          state_next = DONE;
        end else if (adc_valid_in && (wc == WC_LAST)) begin
          state_next = TIMEOUT;
        end else begin
          state_next = SEARCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Calibration state, word counter, flags and measurement results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      wc             <= '0;
      cal_busy       <= 1'b0;
      cal_done       <= 1'b0;
      cal_timeout    <= 1'b0;
      measured_delay <= 8'd0;
      calib_delay    <= 8'd0;
    end else begin
      state       <= state_next;
      cal_busy    <= (state_next == SEARCH);
      cal_done    <= (state_next == DONE);
      cal_timeout <= (state_next == TIMEOUT);
      // Held at zero outside SEARCH so the first counted word is always wc=0.
      if (state != SEARCH) begin
        wc <= '0;
      end else if (adc_valid_in) begin
        wc <= wc + WC_W'(1);
      end else begin
        wc <= wc;
      end
      if ((state == SEARCH) && adc_valid_in && hit) begin
        measured_delay <= measured_next;
        calib_delay    <= MAX_DELAY - measured_next;
      end else begin
        measured_delay <= measured_delay;
        calib_delay    <= calib_delay;
      end
    end
  end

  // History shift register, aligned output word and applied delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int h = 0; h < NUM_STAGES; h++) begin
        hist[h] <= '0;
      end
      adc_word_out  <= '0;
      adc_valid_out <= 1'b0;
      applied_delay <= 8'd0;
    end else begin
      adc_valid_out <= adc_valid_in;
      applied_delay <= delay_override_en ? clamp_delay(delay_override) : calib_delay;
      if (adc_valid_in) begin
        adc_word_out <= aligned;
        hist[0]      <= adc_word_in;
        for (int h = 1; h < NUM_STAGES; h++) begin
          hist[h] <= hist[h-1];
        end
      end else begin
        adc_word_out <= adc_word_out;
        for (int h = 0; h < NUM_STAGES; h++) begin
          hist[h] <= hist[h];
        end
      end
    end
  end

endmodule
